// File: rtl/riscv_v_v2i_wb_queue_if.sv
// Handshake bundle between the v2i result path, the writeback queue and the scalar writeback port.
interface riscv_v_v2i_wb_queue_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TAG_WIDTH  = 5,
   parameter int unsigned DEPTH      = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic [TAG_WIDTH-1:0]  in_rd;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [TAG_WIDTH-1:0]  out_rd;
   logic [CNT_W-1:0]      count;
   logic                  full;
   logic                  empty;

   // The queue itself.
   modport slave (
      input  in_valid, in_data, in_rd, out_ready,
      output in_ready, out_valid, out_data, out_rd, count, full, empty
   );

   // Producer / consumer side (ALU result path and scalar writeback).
   modport master (
      output in_valid, in_data, in_rd, out_ready,
      input  in_ready, out_valid, out_data, out_rd, count, full, empty
   );
endinterface

// File: rtl/riscv_v_v2i_wb_queue.sv
// First-word fall-through queue holding vector-to-integer results and their scalar rd tag
// until the scalar writeback port takes them; x0-destined results are accepted and dropped.
module riscv_v_v2i_wb_queue #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TAG_WIDTH  = 5,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   riscv_v_v2i_wb_queue_if.slave    q
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [TAG_WIDTH-1:0]  rd;
   } entry_t;

   entry_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               full_c, empty_c;
   logic               push_store_c, pop_c;
   entry_t             head_c;

   assign full_c  = (count_q == CNT_W'(DEPTH));
   assign empty_c = (count_q == CNT_W'(0));

   // in_ready depends only on occupancy, never on out_ready.
   assign push_store_c = q.in_valid && !full_c && !flush && (q.in_rd != TAG_WIDTH'(0));
   assign pop_c        = q.out_ready && !empty_c && !flush;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_store_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_c)        rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push_store_c && !pop_c)      count_d = count_q + CNT_W'(1);
         else if (pop_c && !push_store_c) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; only pointers and occupancy define validity.
   always_ff @(posedge clk) begin
      if (!rst && push_store_c) begin
         mem_q[wr_ptr_q] <= '{data: q.in_data, rd: q.in_rd};
      end
   end

   assign head_c = empty_c ? entry_t'(0) : mem_q[rd_ptr_q];

   assign q.in_ready  = !full_c;
   assign q.out_valid = !empty_c;
   assign q.out_data  = head_c.data;
   assign q.out_rd    = head_c.rd;
   assign q.count     = count_q;
   assign q.full      = full_c;
   assign q.empty     = empty_c;
endmodule

// File: tb/tb_riscv_v_v2i_wb_queue.sv
// Directed plus randomized bench for the v2i writeback queue against a queue-based reference model.
module tb_riscv_v_v2i_wb_queue;
   localparam int unsigned DW    = 32;
   localparam int unsigned TW    = 5;
   localparam int unsigned DEPTH = 4;

   logic clk;
   logic rst;
   logic flush;
   int   n_cmp;
   int   n_err;

   logic [DW+TW-1:0] mq [$];

   riscv_v_v2i_wb_queue_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) qif ();

   riscv_v_v2i_wb_queue #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .q     (qif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic        ev;
      logic [31:0] ed;
      logic [31:0] er;
      ev = (mq.size() != 0);
      ed = ev ? 32'(mq[0][DW+TW-1:TW]) : 32'd0;
      er = ev ? 32'(mq[0][TW-1:0]) : 32'd0;
      chk("count",     32'(qif.count),     32'(mq.size()));
      chk("out_valid", 32'(qif.out_valid), 32'(ev));
      chk("out_data",  qif.out_data,       ed);
      chk("out_rd",    32'(qif.out_rd),    er);
      chk("full",      32'(qif.full),      32'(mq.size() == DEPTH));
      chk("empty",     32'(qif.empty),     32'(mq.size() == 0));
      chk("in_ready",  32'(qif.in_ready),  32'(mq.size() != DEPTH));
      chk("inv_count_le_depth", 32'(qif.count <= 3'(DEPTH)), 32'd1);
      chk("inv_not_full_and_empty", 32'(qif.full && qif.empty), 32'd0);
   endtask

   // One clock: predict from pre-edge inputs and occupancy, then compare after the edge.
   task automatic step();
      int               sz;
      bit               do_pop, do_push, clr;
      logic [DW+TW-1:0] e;
      sz      = mq.size();
      clr     = rst || flush;
      do_pop  = (sz > 0) && qif.out_ready;
      do_push = qif.in_valid && (sz < DEPTH) && (qif.in_rd != '0);
      e       = {qif.in_data, qif.in_rd};
      @(posedge clk);
      #1;
      if (clr) mq.delete();
      else begin
         if (do_pop)  void'(mq.pop_front());
         if (do_push) mq.push_back(e);
      end
      check_outputs();
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] rd, input logic rdy);
      qif.in_valid  = v;
      qif.in_data   = d;
      qif.in_rd     = rd;
      qif.out_ready = rdy;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      flush = 1'b0;
      drive(1'b0, 32'd0, 5'd0, 1'b0);
      step();
      step();
      rst = 1'b0;
      step();

      // Single push, stall three cycles, then pop.
      drive(1'b1, 32'hDEADBEEF, 5'd5, 1'b0);
      step();
      drive(1'b0, 32'd0, 5'd0, 1'b0);
      for (int i = 0; i < 3; i++) step();
      qif.out_ready = 1'b1;
      step();
      qif.out_ready = 1'b0;

      // Fill to full, try an extra push, then drain in order.
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 32'(i * 'h11), 5'(i), 1'b0);
         step();
      end
      drive(1'b1, 32'h55, 5'd7, 1'b0);
      step();
      qif.out_ready = 1'b1;
      #1;
      chk("in_ready_full_with_out_ready", 32'(qif.in_ready), 32'd0);
      step();
      qif.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();

      // Steady push+pop at count 2 with pointer wrap.
      drive(1'b1, 32'h100, 5'd1, 1'b0);
      step();
      drive(1'b1, 32'h101, 5'd2, 1'b0);
      step();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'(32'h102 + i), 5'(3 + i), 1'b1);
         step();
      end
      drive(1'b0, 32'd0, 5'd0, 1'b1);
      step();
      step();

      // x0 destination: handshake completes, nothing stored.
      drive(1'b1, 32'hFFFFFFFF, 5'd0, 1'b0);
      #1;
      chk("in_ready_x0", 32'(qif.in_ready), 32'd1);
      step();
      qif.in_valid = 1'b0;
      step();

      // Reset mid-stream with two entries queued and transfers pending.
      drive(1'b1, 32'hA1, 5'd9, 1'b0);
      step();
      drive(1'b1, 32'hA2, 5'd10, 1'b0);
      step();
      drive(1'b1, 32'hA3, 5'd11, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      drive(1'b0, 32'd0, 5'd0, 1'b0);
      step();

      // Flush with three entries queued while push and pop are both requested.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'(32'hB0 + i), 5'(12 + i), 1'b0);
         step();
      end
      drive(1'b1, 32'hBEEF, 5'd20, 1'b1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, 32'd0, 5'd0, 1'b1);
      step();
      step();

      // Randomized traffic with occasional x0, flush and reset.
      for (int i = 0; i < 600; i++) begin
         drive(($urandom % 4) != 0, $urandom,
               (($urandom % 8) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               ($urandom % 3) != 0);
         flush = (($urandom % 40) == 0);
         rst   = (($urandom % 90) == 0);
         step();
      end
      rst   = 1'b0;
      flush = 1'b0;
      drive(1'b0, 32'd0, 5'd0, 1'b1);
      for (int i = 0; i < DEPTH + 1; i++) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
